ieee1355_link_ctrl: RTL and testbench

- Link-state controller for one IEEE1355 DS link inside `node`.
- Sequences the transmitter (`node` `d_outA`/`s_outA`) through reset, NULL exchange, FCT exchange and RUN.
- Shares the link between flow-control characters and data by keeping transmit and receive credit counters.
- Sits between the DS rx decoder, the DS tx encoder and the rx/tx FIFOs.

---
 rtl/ieee1355_pkg.sv | 27 ++
 rtl/ieee1355_credit_cnt.sv | 66 ++++++
 rtl/ieee1355_link_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_ieee1355_link_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ieee1355_pkg.sv
// Shared definitions for the IEEE1355 DS link controller: state encoding,
// flow-control credit size and link timing derived from the system clock.
package ieee1355_pkg;

    typedef enum logic [2:0] {
        ST_ERROR_RESET = 3'd0,
        ST_ERROR_WAIT  = 3'd1,
        ST_READY       = 3'd2,
        ST_STARTED     = 3'd3,
        ST_CONNECTING  = 3'd4,
        ST_RUN         = 3'd5
    } link_state_t;

    // Characters granted by one FCT.
    localparam int C_FCT_CREDIT = 8;

    // Link timing is specified in nanoseconds and converted to clock cycles.
    localparam int C_CLK_MHZ     = 100;
    localparam int C_T_RESET_NS  = 6400;
    localparam int C_T_WAIT_NS   = 12800;
    localparam int C_T_RESET_CYC = (C_T_RESET_NS * C_CLK_MHZ) / 1000;
    localparam int C_T_WAIT_CYC  = (C_T_WAIT_NS * C_CLK_MHZ) / 1000;

    // Credit ceiling in characters, a whole number of FCTs.
    localparam int C_MAX_CREDIT = 56;

endpackage

// File: rtl/ieee1355_credit_cnt.sv
// Credit counter: adds one FCT worth of credit, removes one character.
// The sum saturates at the ceiling and at zero; err reports the selected
// overflow (FCT above the ceiling) and/or underflow (character with no credit).
module ieee1355_credit_cnt
    import ieee1355_pkg::*;
#(
    parameter int G_MAX        = C_MAX_CREDIT,
    parameter bit G_OVF_IS_ERR = 1'b1,
    parameter bit G_UNF_IS_ERR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [6:0] count,
    output logic       err
);

    localparam logic [7:0] C_MAX_S     = 8'(G_MAX);
    localparam logic [7:0] C_STEP_S    = 8'(C_FCT_CREDIT);
    localparam logic [6:0] C_INC_LIM_S = 7'(G_MAX - C_FCT_CREDIT);

    logic [6:0] count_r;
    logic [6:0] count_nxt_s;
    logic [7:0] sum_s;
    logic [7:0] capped_s;
    logic       ovf_s;
    logic       unf_s;

    // Detect an increment that would pass the ceiling and a decrement of an empty counter.
    always_comb begin
        ovf_s = inc & (count_r > C_INC_LIM_S);
        unf_s = dec & ~inc & (count_r == 7'd0);
        err   = (G_OVF_IS_ERR & ovf_s) | (G_UNF_IS_ERR & unf_s);
    end

    // Add the FCT step capped at the ceiling, then remove one character unless already empty.
    always_comb begin
        sum_s = {1'b0, count_r} + (inc ? C_STEP_S : 8'd0);
        if (sum_s > C_MAX_S) begin
            capped_s = C_MAX_S;
        end else begin
            capped_s = sum_s;
        end
        if (dec && (capped_s != 8'd0)) begin
            count_nxt_s = 7'(capped_s - 8'd1);
        end else begin
            count_nxt_s = capped_s[6:0];
        end
    end

    // Counter register; clr empties it on every entry into link reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 7'd0;
        end else if (clr) begin
            count_r <= 7'd0;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/ieee1355_link_ctrl.sv
// Link-state controller for one IEEE1355 DS link: walks the transmitter
// through reset, NULL exchange, FCT exchange and RUN, and keeps the
// transmit and receive credit counts that gate data and FCT traffic.
module ieee1355_link_ctrl
    import ieee1355_pkg::*;
#(
    parameter int G_T_RESET_CYC = C_T_RESET_CYC,
    parameter int G_T_WAIT_CYC  = C_T_WAIT_CYC,
    parameter int G_MAX_CREDIT  = C_MAX_CREDIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       link_start,
    input  logic       link_autostart,
    input  logic       link_disable,
    input  logic       rx_got_null,
    input  logic       rx_got_fct,
    input  logic       rx_got_data,
    input  logic       rx_err,
    input  logic [6:0] rx_fifo_space,
    input  logic       tx_fct_sent,
    input  logic       tx_char_sent,
    output logic       rx_en,
    output logic       tx_en,
    output logic       tx_fct_req,
    output logic       tx_char_ok,
    output logic [2:0] link_state,
    output logic       link_up,
    output logic       link_err
);

    localparam logic [10:0] C_RESET_LAST = 11'(G_T_RESET_CYC - 1);
    localparam logic [10:0] C_WAIT_LAST  = 11'(G_T_WAIT_CYC - 1);
    localparam logic [7:0]  C_MAX_S      = 8'(G_MAX_CREDIT);
    localparam logic [7:0]  C_STEP_S     = 8'(C_FCT_CREDIT);

    link_state_t state_r;
    link_state_t state_nxt_s;
    logic [10:0] timer_r;
    logic        got_null_r;
    logic        link_err_r;
    logic        timeout_s;
    logic        fault_s;
    logic        clr_s;
    logic        credit_act_s;
    logic        tx_cerr_s;
    logic        rx_cerr_s;
    logic [6:0]  tx_credit_s;
    logic [6:0]  rx_out_s;
    logic [7:0]  rx_need_s;

    // Timeout on the last cycle of the current state's budget; READY and RUN never time out.
    always_comb begin
        case (state_r)
            ST_ERROR_RESET:                           timeout_s = (timer_r == C_RESET_LAST);
            ST_ERROR_WAIT, ST_STARTED, ST_CONNECTING: timeout_s = (timer_r == C_WAIT_LAST);
            default:                                  timeout_s = 1'b0;
        endcase
    end

    // Next state; any error outranks a progress transition in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        fault_s     = 1'b0;
        case (state_r)
            ST_ERROR_RESET: begin
                if (timeout_s) begin
                    state_nxt_s = ST_ERROR_WAIT;
                end else begin
                    state_nxt_s = ST_ERROR_RESET;
                end
            end
            ST_ERROR_WAIT: begin
                if (rx_err | rx_got_fct | rx_got_data) begin
                    fault_s     = 1'b1;
                    state_nxt_s = ST_ERROR_RESET;
                end else if (timeout_s) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_ERROR_WAIT;
                end
            end
            ST_READY: begin
                if (rx_err | rx_got_fct | rx_got_data) begin
                    fault_s     = 1'b1;
                    state_nxt_s = ST_ERROR_RESET;
                end else if (!link_disable && (link_start || (link_autostart && got_null_r))) begin
                    state_nxt_s = ST_STARTED;
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            ST_STARTED: begin
                if (rx_err | rx_got_fct | rx_got_data | timeout_s) begin
                    fault_s     = 1'b1;
                    state_nxt_s = ST_ERROR_RESET;
                end else if (rx_got_null | got_null_r) begin
                    state_nxt_s = ST_CONNECTING;
                end else begin
                    state_nxt_s = ST_STARTED;
                end
            end
            ST_CONNECTING: begin
                if (rx_err | rx_got_data | timeout_s) begin
                    fault_s     = 1'b1;
                    state_nxt_s = ST_ERROR_RESET;
                end else if (rx_got_fct) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_CONNECTING;
                end
            end
            ST_RUN: begin
                if (rx_err | tx_cerr_s | rx_cerr_s) begin
                    fault_s     = 1'b1;
                    state_nxt_s = ST_ERROR_RESET;
                end else if (link_disable) begin
                    state_nxt_s = ST_ERROR_RESET;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                fault_s     = 1'b1;
                state_nxt_s = ST_ERROR_RESET;
            end
        endcase
    end

    // Credits only move once FCT exchange is enabled and are wiped on any entry to reset.
    assign clr_s        = (state_nxt_s == ST_ERROR_RESET);
    assign credit_act_s = (state_r == ST_CONNECTING) | (state_r == ST_RUN);

    ieee1355_credit_cnt #(
        .G_MAX        (G_MAX_CREDIT),
        .G_OVF_IS_ERR (1'b1),
        .G_UNF_IS_ERR (1'b0)
    ) u_tx_credit (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_s),
        .inc   (rx_got_fct & credit_act_s),
        .dec   (tx_char_sent & (state_r == ST_RUN)),
        .count (tx_credit_s),
        .err   (tx_cerr_s)
    );

    ieee1355_credit_cnt #(
        .G_MAX        (G_MAX_CREDIT),
        .G_OVF_IS_ERR (1'b0),
        .G_UNF_IS_ERR (1'b1)
    ) u_rx_out (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_s),
        .inc   (tx_fct_sent & credit_act_s),
        .dec   (rx_got_data & (state_r == ST_RUN)),
        .count (rx_out_s),
        .err   (rx_cerr_s)
    );

    // State register, per-state timer, NULL-seen flag and the link_err pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_ERROR_RESET;
            timer_r    <= 11'd0;
            got_null_r <= 1'b0;
            link_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            link_err_r <= fault_s;
            if (state_nxt_s != state_r) begin
                timer_r <= 11'd0;
            end else if (timer_r != 11'h7FF) begin
                timer_r <= timer_r + 11'd1;
            end else begin
                timer_r <= timer_r;
            end
            if (clr_s) begin
                got_null_r <= 1'b0;
            end else begin
                got_null_r <= got_null_r | (rx_got_null & (state_r != ST_ERROR_RESET));
            end
        end
    end

    // Ask for an FCT only while another 8 characters fit both the ceiling and the rx FIFO.
    always_comb begin
        rx_need_s  = {1'b0, rx_out_s} + C_STEP_S;
        tx_fct_req = credit_act_s & (rx_need_s <= C_MAX_S) & ({1'b0, rx_fifo_space} >= rx_need_s);
    end

    assign rx_en      = (state_r != ST_ERROR_RESET);
    assign tx_en      = (state_r == ST_STARTED) | (state_r == ST_CONNECTING) | (state_r == ST_RUN);
    assign tx_char_ok = (state_r == ST_RUN) & (tx_credit_s != 7'd0);
    assign link_state = state_r;
    assign link_up    = (state_r == ST_RUN);
    assign link_err   = link_err_r;

endmodule

// File: tb/tb_ieee1355_link_ctrl.sv
// Bench for ieee1355_link_ctrl: directed bring-up/credit scenarios followed by
// randomized traffic, all compared every cycle against a behavioural link model.
module tb_ieee1355_link_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       link_start = 1'b0, link_autostart = 1'b0, link_disable = 1'b0;
    logic       rx_got_null = 1'b0, rx_got_fct = 1'b0, rx_got_data = 1'b0, rx_err = 1'b0;
    logic [6:0] rx_fifo_space = 7'd64;
    logic       tx_fct_sent = 1'b0, tx_char_sent = 1'b0;
    logic       rx_en, tx_en, tx_fct_req, tx_char_ok, link_up, link_err;
    logic [2:0] link_state;

    localparam logic [5:0] E_NULL  = 6'b100000;
    localparam logic [5:0] E_FCT   = 6'b010000;
    localparam logic [5:0] E_DATA  = 6'b001000;
    localparam logic [5:0] E_ERR   = 6'b000100;
    localparam logic [5:0] E_FSENT = 6'b000010;
    localparam logic [5:0] E_SENT  = 6'b000001;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: state number 0..5, cycles spent in it, credits, NULL seen, error pulse.
    int m_st = 0, m_tmr = 0, m_txc = 0, m_rxo = 0;
    bit m_gn = 1'b0, m_err = 1'b0;

    always #5 clk = ~clk;

    ieee1355_link_ctrl dut (
        .clk(clk), .rst(rst), .link_start(link_start), .link_autostart(link_autostart),
        .link_disable(link_disable), .rx_got_null(rx_got_null), .rx_got_fct(rx_got_fct),
        .rx_got_data(rx_got_data), .rx_err(rx_err), .rx_fifo_space(rx_fifo_space),
        .tx_fct_sent(tx_fct_sent), .tx_char_sent(tx_char_sent), .rx_en(rx_en), .tx_en(tx_en),
        .tx_fct_req(tx_fct_req), .tx_char_ok(tx_char_ok), .link_state(link_state),
        .link_up(link_up), .link_err(link_err)
    );

    function automatic int time_budget(input int st);
        case (st)
            0:       return 640;
            1, 3, 4: return 1280;
            default: return 0;
        endcase
    endfunction

    // Behavioural link model: linear progression 0->5, fatal events per state, credit arithmetic.
    always @(posedge clk or posedge rst) begin : model
        int  nst, ntx, nrx, lim;
        bit  tmo, flt, adv;
        if (rst) begin
            m_st <= 0; m_tmr <= 0; m_txc <= 0; m_rxo <= 0; m_gn <= 1'b0; m_err <= 1'b0;
        end else begin
            lim = time_budget(m_st);
            tmo = (lim != 0) && (m_tmr == lim - 1);
            case (m_st)
                1, 2:    flt = rx_err || rx_got_fct || rx_got_data;
                3:       flt = rx_err || rx_got_fct || rx_got_data || tmo;
                4:       flt = rx_err || rx_got_data || tmo;
                5:       flt = rx_err || (rx_got_fct && m_txc > 56 - 8) ||
                               (rx_got_data && m_rxo == 0 && !tx_fct_sent);
                default: flt = 1'b0;
            endcase
            case (m_st)
                0, 1:    adv = tmo;
                2:       adv = !link_disable && (link_start || (link_autostart && m_gn));
                3:       adv = rx_got_null || m_gn;
                4:       adv = rx_got_fct;
                default: adv = 1'b0;
            endcase
            if (flt || (m_st == 5 && link_disable)) nst = 0;
            else if (adv)                           nst = m_st + 1;
            else                                    nst = m_st;
            ntx = 0;
            nrx = 0;
            if (nst != 0) begin
                ntx = m_txc;
                nrx = m_rxo;
                if (m_st >= 4 && rx_got_fct)  ntx = (ntx + 8 > 56) ? 56 : ntx + 8;
                if (m_st >= 4 && tx_fct_sent) nrx = (nrx + 8 > 56) ? 56 : nrx + 8;
                if (m_st == 5 && tx_char_sent && ntx > 0) ntx = ntx - 1;
                if (m_st == 5 && rx_got_data && nrx > 0)  nrx = nrx - 1;
            end
            m_tmr <= (nst != m_st) ? 0 : ((m_tmr < 2047) ? m_tmr + 1 : m_tmr);
            m_gn  <= (nst == 0) ? 1'b0 : (m_gn || (rx_got_null && m_st != 0));
            m_st  <= nst;
            m_txc <= ntx;
            m_rxo <= nrx;
            m_err <= flt;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model's view of the current cycle.
    task automatic cmp_outputs();
        logic [8:0] exp_v, act_v;
        bit req;
        req = (m_st == 4 || m_st == 5) && (m_rxo + 8 <= 56) && (int'(rx_fifo_space) >= m_rxo + 8);
        exp_v = {m_st != 0, m_st >= 3, req, (m_st == 5) && (m_txc != 0), 3'(m_st), m_st == 5, m_err};
        act_v = {rx_en, tx_en, tx_fct_req, tx_char_ok, link_state, link_up, link_err};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t got %b expected %b (rx_en,tx_en,fct_req,char_ok,state,up,err)",
                     $time, act_v, exp_v);
        end
    endtask

    // One clock: compare on the falling edge, return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        cmp_outputs();
        @(posedge clk);
        #2;
    endtask

    task automatic ev(input logic [5:0] v);
        {rx_got_null, rx_got_fct, rx_got_data, rx_err, tx_fct_sent, tx_char_sent} = v;
        tick();
        {rx_got_null, rx_got_fct, rx_got_data, rx_err, tx_fct_sent, tx_char_sent} = 6'b0;
    endtask

    task automatic wait_state(input int target, input int bound, input string name);
        int n = 0;
        while (int'(link_state) != target && n < bound) begin
            tick();
            n++;
        end
        chk(name, int'(link_state), target);
    endtask

    // From a fresh ERROR_RESET with link_start high: NULL in STARTED, FCT 20 cycles later.
    task automatic bring_up();
        wait_state(3, 2500, "reach_started");
        ev(E_NULL);
        chk("connecting", int'(link_state), 4);
        repeat (19) tick();
        ev(E_FCT);
        chk("run", int'(link_state), 5);
    endtask

    function automatic bit one_in(input int n);
        return ($urandom_range(0, n - 1) == 0);
    endfunction

    initial begin
        link_start = 1'b1;
        repeat (3) tick();
        chk("reset_state", int'(link_state), 0);
        chk("reset_outs", int'({rx_en, tx_en, tx_fct_req, tx_char_ok, link_up, link_err}), 0);
        rst = 1'b0;

        // Timing of the reset/wait sequence and the STARTED timeout.
        repeat (639) tick();
        chk("er_last_cycle", int'(link_state), 0);
        tick();
        chk("to_error_wait", int'(link_state), 1);
        chk("model_to_error_wait", m_st, 1);
        repeat (1279) tick();
        chk("ew_last_cycle", int'(link_state), 1);
        tick();
        chk("to_ready", int'(link_state), 2);
        tick();
        chk("to_started", int'(link_state), 3);
        repeat (1279) tick();
        chk("started_last_cycle", int'(link_state), 3);
        tick();
        chk("started_timeout", int'(link_state), 0);
        chk("timeout_link_err", int'(link_err), 1);
        tick();
        chk("link_err_one_cycle", int'(link_err), 0);

        // Full bring-up and transmit credit.
        bring_up();
        chk("run_link_up", int'(link_up), 1);
        chk("run_char_ok", int'(tx_char_ok), 1);
        chk("model_txc_8", m_txc, 8);
        repeat (8) ev(E_SENT);
        chk("credit_drained_ok", int'(tx_char_ok), 0);
        chk("model_txc_0", m_txc, 0);
        ev(E_SENT);
        chk("sent_at_zero_ignored", int'(link_state), 5);
        ev(E_FCT);
        chk("refill_ok", int'(tx_char_ok), 1);
        ev(E_FCT | E_SENT);
        chk("model_txc_15", m_txc, 15);
        repeat (15) ev(E_SENT);
        chk("drain15_ok", int'(tx_char_ok), 0);
        repeat (7) ev(E_FCT);
        chk("model_txc_56", m_txc, 56);
        chk("full_credit_run", int'(link_state), 5);
        ev(E_FCT);
        chk("credit_ovf_state", int'(link_state), 0);
        chk("credit_ovf_err", int'(link_err), 1);
        chk("model_txc_cleared", m_txc, 0);

        // Receive credit and FCT requests.
        bring_up();
        rx_fifo_space = 7'd7;
        #1;
        chk("fct_req_fifo_7", int'(tx_fct_req), 0);
        rx_fifo_space = 7'd8;
        #1;
        chk("fct_req_fifo_8", int'(tx_fct_req), 1);
        rx_fifo_space = 7'd64;
        for (int i = 0; i < 7; i++) begin
            chk("fct_req_before_send", int'(tx_fct_req), 1);
            ev(E_FSENT);
        end
        chk("fct_req_at_56", int'(tx_fct_req), 0);
        chk("model_rxo_56", m_rxo, 56);
        repeat (56) ev(E_DATA);
        chk("model_rxo_0", m_rxo, 0);
        chk("drain_rx_run", int'(link_state), 5);
        ev(E_DATA);
        chk("rx_underflow_state", int'(link_state), 0);
        chk("rx_underflow_err", int'(link_err), 1);

        // Error coinciding with FCT in CONNECTING.
        wait_state(3, 2500, "reach_started_2");
        ev(E_NULL);
        repeat (5) tick();
        ev(E_ERR | E_FCT);
        chk("err_beats_fct", int'(link_state), 0);
        chk("err_beats_fct_err", int'(link_err), 1);

        // Asynchronous reset in RUN.
        bring_up();
        rst = 1'b1;
        #1;
        chk("async_rst_state", int'(link_state), 0);
        chk("async_rst_outs", int'({rx_en, tx_en, tx_fct_req, tx_char_ok, link_up, link_err}), 0);
        tick();
        rst = 1'b0;

        // Disable in RUN leaves quietly; autostart waits for a received NULL.
        bring_up();
        link_disable = 1'b1;
        tick();
        link_disable = 1'b0;
        chk("disable_state", int'(link_state), 0);
        chk("disable_no_err", int'(link_err), 0);
        link_start = 1'b0;
        link_autostart = 1'b1;
        wait_state(2, 2500, "reach_ready");
        repeat (5) tick();
        chk("autostart_waits", int'(link_state), 2);
        ev(E_NULL);
        chk("autostart_flag_cycle", int'(link_state), 2);
        tick();
        chk("autostart_started", int'(link_state), 3);
        tick();
        chk("got_null_connecting", int'(link_state), 4);

        // Randomized traffic shaped by the model's current state.
        for (int c = 0; c < 30000; c++) begin
            link_start     = !one_in(10);
            link_autostart = one_in(2);
            link_disable   = one_in(3000);
            if (one_in(50)) rx_fifo_space = 7'($urandom_range(0, 127));
            rx_got_null  = (m_st >= 1 && m_st <= 3) && one_in(50);
            rx_got_fct   = (m_st == 4) ? one_in(20) :
                           (m_st == 5) ? ((m_txc <= 48) ? one_in(6) : one_in(300)) : one_in(6000);
            rx_got_data  = (m_st == 5 && m_rxo > 0) ? one_in(3) : one_in(6000);
            rx_err       = one_in(9000);
            tx_fct_sent  = (m_st >= 4 && m_rxo <= 48) ? one_in(3) : 1'b0;
            tx_char_sent = (m_st == 5) ? one_in(2) : 1'b0;
            tick();
        end
        {rx_got_null, rx_got_fct, rx_got_data, rx_err, tx_fct_sent, tx_char_sent} = 6'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
